// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and funct3 codes for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extract/extend, store merge and access legality check
module lsu_align
    import lsu_pkg::*;
(
    input  logic        chk_store,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_lane,
    output logic        err,
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word
);

    logic        illegal;
    logic        misaligned;
    logic [31:0] shifted;

    always_comb begin
        if (chk_store) begin
            illegal = chk_funct3[2] || (chk_funct3 == 3'b011);
        end else begin
            illegal = (chk_funct3 == 3'b011) || (chk_funct3 == 3'b110) || (chk_funct3 == 3'b111);
        end
        misaligned = ((chk_funct3[1:0] == 2'b01) && chk_lane[0]) ||
                     ((chk_funct3[1:0] == 2'b10) && (chk_lane != 2'b00));
        err = illegal || misaligned;
    end

    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Sub-word stores patch the lane(s) of the previously read word.
    always_comb begin
        store_word = old_word;
        case (funct3)
            F3_B:    store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator with RMW sub-word stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t         state, state_nxt;
    logic [2:0]         f3_q;
    logic [DEPTH_W+1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        merge_q;
    logic               req_err;
    logic [31:0]        load_data;
    logic [31:0]        store_word;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:DEPTH_W+2];

    lsu_align u_align (
        .chk_store  (req_store),
        .chk_funct3 (req_funct3),
        .chk_lane   (req_addr[1:0]),
        .err        (req_err),
        .rd_word    (mem_rd),
        .lane       (addr_q[1:0]),
        .funct3     (f3_q),
        .load_data  (load_data),
        .old_word   (merge_q),
        .wdata      (wdata_q),
        .store_word (store_word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)               state_nxt = RESP;
                    else if (!req_store)       state_nxt = LOAD;
                    else if (req_funct3 == F3_W) state_nxt = STORE;
                    else                       state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            RMW_RD:  state_nxt = STORE;
            STORE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[DEPTH_W+1:0];
                        wdata_q <= req_wdata;
                        // Response fields only change on the way into RESP.
                        if (req_err) begin
                            resp_rdata <= 32'h0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                RMW_RD: merge_q <= mem_rd;
                STORE: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // All handshake and memory strobes decode from the state register alone.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_we     = (state == STORE);
        mem_addr   = 32'h0;
        mem_wd     = 32'h0;
        if (state == LOAD || state == RMW_RD || state == STORE) begin
            mem_addr = {{(32-DEPTH_W){1'b0}}, addr_q[DEPTH_W+1:2]};
        end
        if (state == STORE) begin
            mem_wd = store_word;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    int n_chk = 0;
    int n_pass = 0;
    int we_total = 0;
    int resp_total = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wd;
    end

    always @(negedge clk) begin
        if (mem_we) we_total++;
        if (resp_valid) resp_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: byte-granular view of the access rules.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                  output logic [31:0] nw, output int lat);
        int nbytes;
        int off;
        bit legal;
        logic [31:0] w;
        logic [31:0] mask;
        nbytes = 1 << f3[1:0];
        off    = int'(a[1:0]);
        w      = ref_mem[a[11:2]];
        legal  = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
        err    = !legal || (off % nbytes != 0);
        rd     = 32'h0;
        nw     = w;
        lat    = 1;
        if (!err && !st) begin
            lat  = 2;
            mask = (nbytes == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
            rd   = (w >> (8 * off)) & mask;
            if (!f3[2] && nbytes < 4 && rd[8 * nbytes - 1]) rd = rd | ~mask;
        end else if (!err) begin
            lat = (nbytes == 4) ? 2 : 3;
            for (int i = 0; i < nbytes; i++) nw[8 * (off + i) +: 8] = wd[8 * i +: 8];
        end
    endfunction

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] e_word;
        int          e_lat;
        int          lat;
        int          nwe;
        int          waited;
        bit          busy_ok;
        bit          done;
        model(st, f3, a, wd, e_err, e_rd, e_word, e_lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) chk("ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        nwe = 0;
        busy_ok = 1'b1;
        done = 1'b0;
        lat = 1;
        while (!done && lat <= 10) begin
            if (req_ready) busy_ok = 1'b0;
            if (mem_we) begin
                nwe++;
                chk("we_addr", mem_addr, {22'h0, a[11:2]});
                chk("we_data", mem_wd, e_word);
            end
            if (resp_valid) done = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_rdata", resp_rdata, e_rd);
        chk("we_count", 32'(nwe), (st && !e_err) ? 32'd1 : 32'd0);
        chk("busy_ready", 32'(busy_ok), 32'd1);
        if (st && !e_err) ref_mem[a[11:2]] = e_word;
        chk("mem_word", mem[a[11:2]], ref_mem[a[11:2]]);
        got = resp_rdata;
    endtask

    initial begin
        logic [31:0] got;
        int acc;
        int seen;
        int we0;
        int resp0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[7]     = 32'h8899AABB;
        ref_mem[7] = 32'h8899AABB;

        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wd", mem_wd, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_req(1'b0, 3'b000, 32'h1D, 32'h0, got); chk("lb_1d", got, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h1D, 32'h0, got); chk("lbu_1d", got, 32'h000000AA);
        do_req(1'b0, 3'b001, 32'h1E, 32'h0, got); chk("lh_1e", got, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h1E, 32'h0, got); chk("lhu_1e", got, 32'h00008899);
        do_req(1'b0, 3'b010, 32'h1C, 32'h0, got); chk("lw_1c", got, 32'h8899AABB);
        do_req(1'b1, 3'b000, 32'h1C, 32'h12345655, got); chk("sb_word7", mem[7], 32'h8899AA55);
        do_req(1'b1, 3'b001, 32'h1E, 32'h0000CAFE, got); chk("sh_word7", mem[7], 32'hCAFEAA55);
        do_req(1'b0, 3'b010, 32'h1E, 32'h0, got); chk("lw_misal_err", 32'(resp_err), 32'd1);
        do_req(1'b1, 3'b001, 32'h1D, 32'h0000BEEF, got); chk("sh_misal_err", 32'(resp_err), 32'd1);
        do_req(1'b0, 3'b011, 32'h1C, 32'h0, got); chk("ld_f3_011_err", 32'(resp_err), 32'd1);
        chk("err_mem_kept", mem[7], 32'hCAFEAA55);

        // Held request: accepted once per pass through IDLE.
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h1C;
        acc = 0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (req_ready) acc++;
            if (resp_valid) seen++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("held_accepts", 32'(acc), 32'd3);
        chk("held_resps", 32'(seen), 32'd2);
        repeat (2) @(negedge clk);

        // Reset while the byte store is between its read and write.
        we0   = we_total;
        resp0 = resp_total;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h1C;
        req_wdata  = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_we", 32'(mem_we), 32'd0);
        chk("rstmid_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_no_we", 32'(we_total), 32'(we0));
        chk("rstmid_no_resp", 32'(resp_total), 32'(resp0));
        chk("rstmid_mem", mem[7], ref_mem[7]);

        do_req(1'b1, 3'b010, 32'h1C, 32'hDEADBEEF, got); chk("sw_word7", mem[7], 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h1C, 32'h0, got); chk("lw_after_sw", got, 32'hDEADBEEF);

        for (int n = 0; n < 150; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 63)), $urandom, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
